// File: rtl/fir_pkg.sv
// Shared definitions for the FIR AXI-Lite control slice: register map,
// ap_ctrl bit positions and read-FSM encodings.
package fir_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned ADDR_DATA_LEN = 32'h10;
  localparam int unsigned ADDR_TAP_BASE = 32'h80;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;
  localparam int unsigned XN_READY_BIT = 4;
  localparam int unsigned YN_VALID_BIT = 5;

  localparam logic [1:0] RIDLE = 2'd0;
  localparam logic [1:0] RADDR = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;

  // Word-aligned byte address inside the tap window of num coefficients.
  function automatic logic is_tap_addr(input logic [31:0] addr, input int unsigned num);
    return (addr[1:0] == 2'b00) && (addr >= ADDR_TAP_BASE) && (addr < ADDR_TAP_BASE + 4 * num);
  endfunction

endpackage

// File: rtl/fir_axilite_ctrl_if.sv
// AXI-Lite write/read channel bundle between the host and the FIR control slave.
interface fir_axilite_ctrl_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_axilite_rd.sv
// AXI-Lite read channel: RIDLE -> RADDR -> RDATA, with the register/tap rdata mux.
module fir_axilite_rd
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  input  logic [pADDR_WIDTH-1:0] araddr_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [pDATA_WIDTH-1:0] rdata_o,
  input  logic                   stall_i,
  input  logic                   busy_i,
  input  logic [pDATA_WIDTH-1:0] ctrl_val_i,
  input  logic [pDATA_WIDTH-1:0] len_val_i,
  input  logic [pDATA_WIDTH-1:0] tap_do_i,
  output logic                   bram_req_o,
  output logic [pADDR_WIDTH-1:0] bram_addr_o,
  output logic                   ctrl_ack_o
);

  localparam logic [pADDR_WIDTH-1:0] CtrlAddr = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] LenAddr  = pADDR_WIDTH'(ADDR_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] TapBase  = pADDR_WIDTH'(ADDR_TAP_BASE);

  logic [1:0]             state_q, state_d;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   live_q, live_d;
  logic                   tap_hit;

  assign tap_hit = is_tap_addr(32'(addr_q), Tape_Num);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    live_d  = 1'b0;
    case (state_q)
      RIDLE: begin
        if (arvalid_i) begin
          addr_d  = araddr_i;
          state_d = RADDR;
        end
      end
      RADDR: begin
        // A concurrent write commit owns the BRAM port; retry next cycle.
        if (!stall_i) begin
          state_d = RDATA;
          if (tap_hit) begin
            if (busy_i) rdata_d = '1;
            else        live_d  = 1'b1;
          end else if (addr_q == CtrlAddr) begin
            rdata_d = ctrl_val_i;
          end else if (addr_q == LenAddr) begin
            rdata_d = len_val_i;
          end else begin
            rdata_d = '0;
          end
        end
      end
      RDATA: begin
        // BRAM data is only valid on the first RDATA cycle; hold it afterwards.
        if (live_q)   rdata_d = tap_do_i;
        if (rready_i) state_d = RIDLE;
      end
      default: state_d = RIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RIDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      live_q  <= live_d;
    end
  end

  assign arready_o   = (state_q == RIDLE);
  assign rvalid_o    = (state_q == RDATA);
  assign rdata_o     = live_q ? tap_do_i : rdata_q;
  assign bram_req_o  = (state_q == RADDR) && tap_hit;
  assign bram_addr_o = addr_q - TapBase;
  assign ctrl_ack_o  = rvalid_o && rready_i && (addr_q == CtrlAddr);

endmodule

// File: rtl/fir_axilite_ctrl.sv
// AXI-Lite control/config slave for the FIR engine: ap_ctrl, data_length and
// arbitration of the single-port tap BRAM between host and engine.
module fir_axilite_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  fir_axilite_ctrl_if.slave      axi,
  output logic                   ap_start,
  input  logic                   reset_ap_start,
  input  logic                   ap_done_in,
  input  logic                   xn_ready,
  input  logic                   yn_valid,
  output logic [pDATA_WIDTH-1:0] data_length,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic [pDATA_WIDTH-1:0] eng_tap_Do,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] CtrlAddr = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] LenAddr  = pADDR_WIDTH'(ADDR_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] TapBase  = pADDR_WIDTH'(ADDR_TAP_BASE);

  logic                   aw_full_q, aw_full_d;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                   w_full_q, w_full_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_idle_q, ap_idle_d;
  logic                   ap_done_q, ap_done_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;

  logic                   commit;
  logic                   busy;
  logic                   ctrl_ack;
  logic                   bram_req;
  logic [pADDR_WIDTH-1:0] bram_addr;
  logic [pDATA_WIDTH-1:0] ctrl_val;

  assign commit = aw_full_q && w_full_q;
  assign busy   = !ap_idle_q;

  assign axi.awready = !aw_full_q;
  assign axi.wready  = !w_full_q;

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (axi.awvalid && !aw_full_q) begin
        aw_full_d = 1'b1;
        awaddr_d  = axi.awaddr;
      end
      if (axi.wvalid && !w_full_q) begin
        w_full_d = 1'b1;
        wdata_d  = axi.wdata;
      end
    end
  end

  always_comb begin
    ap_start_d = ap_start_q;
    ap_idle_d  = ap_idle_q;
    ap_done_d  = ap_done_q;
    len_d      = len_q;
    if (ctrl_ack) ap_done_d = 1'b0;
    if (reset_ap_start || ap_done_in) ap_start_d = 1'b0;
    if (ap_done_in) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
    // Control and length writes only land while the engine is idle.
    if (commit && ap_idle_q) begin
      if (awaddr_q == CtrlAddr && wdata_q[AP_START_BIT]) begin
        ap_start_d = 1'b1;
        ap_idle_d  = 1'b0;
      end
      if (awaddr_q == LenAddr) len_d = wdata_q;
    end
  end

  always_comb begin
    ctrl_val               = '0;
    ctrl_val[AP_START_BIT] = ap_start_q;
    ctrl_val[AP_DONE_BIT]  = ap_done_q;
    ctrl_val[AP_IDLE_BIT]  = ap_idle_q;
    ctrl_val[XN_READY_BIT] = xn_ready;
    ctrl_val[YN_VALID_BIT] = yn_valid;
  end

  // BRAM port priority: engine while busy, then host write commit, then host read.
  always_comb begin
    tap_WE = 4'h0;
    tap_EN = 1'b0;
    tap_A  = '0;
    tap_Di = '0;
    if (busy) begin
      tap_EN = 1'b1;
      tap_A  = eng_tap_A;
    end else if (commit && is_tap_addr(32'(awaddr_q), Tape_Num)) begin
      tap_WE = 4'hF;
      tap_EN = 1'b1;
      tap_A  = awaddr_q - TapBase;
      tap_Di = wdata_q;
    end else if (bram_req) begin
      tap_EN = 1'b1;
      tap_A  = bram_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q  <= 1'b0;
      awaddr_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      ap_start_q <= 1'b0;
      ap_idle_q  <= 1'b1;
      ap_done_q  <= 1'b0;
      len_q      <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      awaddr_q   <= awaddr_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      ap_start_q <= ap_start_d;
      ap_idle_q  <= ap_idle_d;
      ap_done_q  <= ap_done_d;
      len_q      <= len_d;
    end
  end

  assign ap_start    = ap_start_q;
  assign data_length = len_q;
  assign eng_tap_Do  = tap_Do;

  fir_axilite_rd #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .Tape_Num    (Tape_Num)
  ) u_rd (
    .clk         (clk),
    .rst         (rst),
    .arvalid_i   (axi.arvalid),
    .arready_o   (axi.arready),
    .araddr_i    (axi.araddr),
    .rvalid_o    (axi.rvalid),
    .rready_i    (axi.rready),
    .rdata_o     (axi.rdata),
    .stall_i     (commit),
    .busy_i      (busy),
    .ctrl_val_i  (ctrl_val),
    .len_val_i   (len_q),
    .tap_do_i    (tap_Do),
    .bram_req_o  (bram_req),
    .bram_addr_o (bram_addr),
    .ctrl_ack_o  (ctrl_ack)
  );

endmodule

// File: tb/tb_fir_axilite_ctrl.sv
// Directed bench for fir_axilite_ctrl: read responses go through a scoreboard
// queue checked by a separate monitor; side-band outputs are checked inline.
module tb_fir_axilite_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ap_start;
  logic        reset_ap_start;
  logic        ap_done_in;
  logic        xn_ready;
  logic        yn_valid;
  logic [31:0] data_length;
  logic [11:0] eng_tap_A;
  logic [31:0] eng_tap_Do;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic [31:0] tap_Di;
  logic [31:0] tap_Do;

  always #5 clk = ~clk;

  fir_axilite_ctrl_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axi ();

  fir_axilite_ctrl #(
    .pADDR_WIDTH (12),
    .pDATA_WIDTH (32),
    .Tape_Num    (11)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axi            (axi),
    .ap_start       (ap_start),
    .reset_ap_start (reset_ap_start),
    .ap_done_in     (ap_done_in),
    .xn_ready       (xn_ready),
    .yn_valid       (yn_valid),
    .data_length    (data_length),
    .eng_tap_A      (eng_tap_A),
    .eng_tap_Do     (eng_tap_Do),
    .tap_WE         (tap_WE),
    .tap_EN         (tap_EN),
    .tap_A          (tap_A),
    .tap_Di         (tap_Di),
    .tap_Do         (tap_Do)
  );

  // Single-port BRAM with one-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[11:2]] <= tap_Di;
      tap_Do <= mem[tap_A[11:2]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] taps [0:10] = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63,
                               32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && axi.rvalid && axi.rready) begin
      if (sb.size() == 0) begin
        fail("unexpected_rvalid", $sformatf("got rdata %h, expected no response", axi.rdata));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, axi.rdata, e.data);
        if (e.due >= 0) chk({e.name, "_lat"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      fail({name, "_resp"}, "no read response within 20 cycles");
      sb.delete();
    end
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp,
                    input int lat);
    bit got = 1'b0;
    int n = 0;
    tick();
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    while (!got && n < 20) begin
      @(negedge clk);
      if (axi.arready) begin
        got = 1'b1;
        sb.push_back('{exp, (lat > 0) ? cyc + lat : -1, name});
      end
      tick();
      n++;
    end
    axi.arvalid = 1'b0;
    if (!got) fail({name, "_ar"}, "arready never asserted");
    else      drain(name);
  endtask

  // Returns at the negedge of the commit cycle after checking tap_WE there.
  task automatic wr(input string name, input logic [11:0] a, input logic [31:0] d,
                    input logic [3:0] we_exp);
    bit aw_ok = 1'b0;
    bit w_ok  = 1'b0;
    int n     = 0;
    tick();
    axi.awvalid = 1'b1;
    axi.awaddr  = a;
    axi.wvalid  = 1'b1;
    axi.wdata   = d;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge clk);
      if (axi.awvalid && axi.awready) aw_ok = 1'b1;
      if (axi.wvalid && axi.wready)   w_ok  = 1'b1;
      tick();
      if (aw_ok) axi.awvalid = 1'b0;
      if (w_ok)  axi.wvalid  = 1'b0;
      n++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    if (!(aw_ok && w_ok)) fail({name, "_hs"}, "write handshake incomplete");
    @(negedge clk);
    chk({name, "_we"}, {28'd0, tap_WE}, {28'd0, we_exp});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b1;
    reset_ap_start = 1'b0; ap_done_in = 1'b0; xn_ready = 1'b0; yn_valid = 1'b0;
    eng_tap_A = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_readies", {29'd0, axi.awready, axi.wready, axi.arready}, 32'd7);
    chk("rst_rvalid", {31'd0, axi.rvalid}, 32'd0);
    chk("rst_rdata", axi.rdata, 32'd0);
    chk("rst_ap_start", {31'd0, ap_start}, 32'd0);
    chk("rst_data_length", data_length, 32'd0);
    chk("rst_tap_WE", {28'd0, tap_WE}, 32'd0);
    rd("rst_ctrl", 12'h000, 32'h4, 2);

    for (int k = 0; k < 11; k++) begin
      a = 12'h080 + 12'(4 * k);
      wr($sformatf("tap%0d_wr", k), a, taps[k], 4'hF);
    end
    for (int k = 0; k < 11; k++) begin
      a = 12'h080 + 12'(4 * k);
      rd($sformatf("tap%0d_rd", k), a, taps[k], 2);
    end
    wr("oob_wr", 12'h0AC, 32'h77, 4'h0);
    rd("oob_rd", 12'h0AC, 32'h0, 2);

    wr("len_wr", 12'h010, 32'd600, 4'h0);
    tick();
    chk("len_port", data_length, 32'd600);
    rd("len_rd", 12'h010, 32'd600, 2);

    wr("start_wr", 12'h000, 32'h1, 4'h0);
    chk("start_pre", {31'd0, ap_start}, 32'd0);
    tick();
    chk("start_set", {31'd0, ap_start}, 32'd1);
    eng_tap_A = 12'h014;
    #1;
    chk("busy_tap_A", {20'd0, tap_A}, 32'h014);
    chk("busy_tap_EN", {31'd0, tap_EN}, 32'd1);
    rd("ctrl_busy", 12'h000, 32'h1, 2);
    wr("len_busy", 12'h010, 32'd7, 4'h0);
    wr("tap_busy", 12'h080, 32'h5555, 4'h0);
    tick();
    chk("len_kept", data_length, 32'd600);
    rd("tap_busy_rd", 12'h084, 32'hFFFF_FFFF, 2);
    eng_tap_A = 12'h008;
    tick();
    chk("busy_tap_A2", {20'd0, tap_A}, 32'h008);
    tick();
    chk("eng_tap_Do", eng_tap_Do, taps[2]);

    tick();
    reset_ap_start = 1'b1;
    @(negedge clk);
    chk("rsa_hold", {31'd0, ap_start}, 32'd1);
    tick();
    reset_ap_start = 1'b0;
    @(negedge clk);
    chk("rsa_clear", {31'd0, ap_start}, 32'd0);
    rd("ctrl_stopped", 12'h000, 32'h0, 2);

    tick();
    ap_done_in = 1'b1;
    tick();
    ap_done_in = 1'b0;
    rd("done_rd", 12'h000, 32'h6, 2);
    rd("done_clr", 12'h000, 32'h4, 2);
    rd("tap0_kept", 12'h080, 32'h0, 2);

    // AW well ahead of W: one tap_WE pulse in the cycle after W.
    tick();
    axi.awvalid = 1'b1;
    axi.awaddr  = 12'h084;
    @(negedge clk);
    chk("skew_aw_rdy", {31'd0, axi.awready}, 32'd1);
    tick();
    axi.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("skew_wait%0d", i), {27'd0, axi.awready, tap_WE}, 32'h0);
      tick();
    end
    axi.wvalid = 1'b1;
    axi.wdata  = 32'h1234;
    @(negedge clk);
    chk("skew_w_rdy", {31'd0, axi.wready}, 32'd1);
    tick();
    axi.wvalid = 1'b0;
    @(negedge clk);
    chk("skew_we", {28'd0, tap_WE}, 32'hF);
    chk("skew_tap_A", {20'd0, tap_A}, 32'h004);
    chk("skew_tap_Di", tap_Di, 32'h1234);
    tick();
    @(negedge clk);
    chk("skew_we_off", {27'd0, axi.awready, tap_WE}, 32'h10);
    rd("skew_rd", 12'h084, 32'h1234, 2);

    // Write commit collides with a tap read in RADDR: write first, read one cycle late.
    tick();
    axi.awvalid = 1'b1; axi.awaddr = 12'h088;
    axi.wvalid  = 1'b1; axi.wdata  = 32'h0000_BEEF;
    axi.arvalid = 1'b1; axi.araddr = 12'h088;
    @(negedge clk);
    chk("same_rdy", {29'd0, axi.awready, axi.wready, axi.arready}, 32'd7);
    sb.push_back('{32'h0000_BEEF, cyc + 3, "same_rd"});
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    @(negedge clk);
    chk("same_we", {28'd0, tap_WE}, 32'hF);
    drain("same_rd");

    // Reset with a read in flight: the response is dropped.
    tick();
    axi.arvalid = 1'b1;
    axi.araddr  = 12'h010;
    @(negedge clk);
    tick();
    axi.arvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_rvalid%0d", i), {31'd0, axi.rvalid}, 32'd0);
    end
    chk("rst_mid_len", data_length, 32'd0);
    rd("rst_mid_ctrl", 12'h000, 32'h4, 2);

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
